// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared cpu constants: exception vector, cause codes, pipe_ctrl FSM states
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_EXC  = 2'd1,
      ST_ERET = 2'd2
   } state_t;

   localparam logic [29:0] EXC_VECTOR  = 30'h0000_0040;
   localparam logic [2:0]  EXP_NONE    = 3'd0;
   localparam logic [2:0]  EXP_EXT_INT = 3'd1;

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/exception controller; PIPE_CTRL_INT_EN enables external interrupts
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        ld_hazard,
   input  logic        br_taken,
   input  logic [29:0] br_addr,
   input  logic        mem_en,
   input  logic [29:0] mem_pc,
   input  logic [2:0]  mem_exp_code,
   input  logic        mem_eret,
   input  logic        int_req,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic        pc_load,
   output logic [29:0] new_pc,
   output logic [29:0] epc,
   output logic [2:0]  exp_code,
   output logic        int_en
);

   state_t      state_q, state_d;
   logic [29:0] epc_q, epc_d;
   logic [2:0]  exp_code_q, exp_code_d;
   logic        int_en_q, int_en_d;

   logic exc_hit, int_hit, eret_hit, bus_wait;

   assign bus_wait = if_busy | mem_busy;
   assign exc_hit  = mem_en & (mem_exp_code != EXP_NONE);
   assign eret_hit = mem_en & mem_eret;

`ifdef PIPE_CTRL_INT_EN
   assign int_hit = int_req & int_en_q;
`else
   logic unused_int_req;
   assign unused_int_req = int_req;
   assign int_hit        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      epc_d      = epc_q;
      exp_code_d = exp_code_q;
      int_en_d   = int_en_q;
      if_stall   = 1'b0;
      id_stall   = 1'b0;
      ex_stall   = 1'b0;
      mem_stall  = 1'b0;
      if_flush   = 1'b0;
      id_flush   = 1'b0;
      ex_flush   = 1'b0;
      mem_flush  = 1'b0;
      pc_load    = 1'b0;
      new_pc     = '0;

      // A bus wait freezes everything, including the exception/ERET sequence.
      if (bus_wait) begin
         {if_stall, id_stall, ex_stall, mem_stall} = 4'hF;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (exc_hit || int_hit) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = 4'hF;
                  pc_load    = 1'b1;
                  new_pc     = EXC_VECTOR;
                  epc_d      = mem_pc;
                  exp_code_d = exc_hit ? mem_exp_code : EXP_EXT_INT;
                  int_en_d   = 1'b0;
                  state_d    = ST_EXC;
               end else if (eret_hit) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = 4'hF;
                  pc_load  = 1'b1;
                  new_pc   = epc_q;
`ifdef PIPE_CTRL_INT_EN
                  int_en_d = 1'b1;
`endif
                  state_d  = ST_ERET;
               end else if (br_taken) begin
                  pc_load  = 1'b1;
                  new_pc   = br_addr;
                  if_flush = 1'b1;
               end else if (ld_hazard) begin
                  if_stall = 1'b1;
                  id_stall = 1'b1;
                  id_flush = 1'b1;
               end
            end
            // Second cycle of the flush window after a redirect.
            ST_EXC, ST_ERET: begin
               {if_flush, id_flush, ex_flush, mem_flush} = 4'hF;
               state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         epc_q      <= '0;
         exp_code_q <= EXP_NONE;
         int_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         epc_q      <= epc_d;
         exp_code_q <= exp_code_d;
         int_en_q   <= int_en_d;
      end
   end

   assign epc      = epc_q;
   assign exp_code = exp_code_q;
   assign int_en   = int_en_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized bench for pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset, if_busy, mem_busy, ld_hazard, br_taken, mem_en, mem_eret, int_req;
   logic [29:0] br_addr, mem_pc;
   logic [2:0]  mem_exp_code;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic        pc_load, int_en;
   logic [29:0] new_pc, epc;
   logic [2:0]  exp_code;

   int n_vec  = 0;
   int n_miss = 0;

   // Model state: cycles of forced flush still owed, and the architectural registers.
   int          m_flush_left, n_flush_left;
   logic [29:0] m_epc, n_epc;
   logic [2:0]  m_code, n_code;
   logic        m_ie, n_ie;
   logic [3:0]  e_stall, e_flush;
   logic        e_pc_load;
   logic [29:0] e_new_pc;
   bit          int_feature;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
      .ld_hazard(ld_hazard), .br_taken(br_taken), .br_addr(br_addr),
      .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
      .mem_eret(mem_eret), .int_req(int_req),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .pc_load(pc_load), .new_pc(new_pc), .epc(epc), .exp_code(exp_code), .int_en(int_en)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_eval();
      bit exc, irq;
      e_stall      = 4'h0;
      e_flush      = 4'h0;
      e_pc_load    = 1'b0;
      e_new_pc     = '0;
      n_flush_left = m_flush_left;
      n_epc        = m_epc;
      n_code       = m_code;
      n_ie         = m_ie;
      exc = mem_en && (mem_exp_code != 3'd0);
      irq = int_feature && int_req && m_ie;
      if (if_busy || mem_busy) begin
         e_stall = 4'hF;
      end else if (m_flush_left > 0) begin
         e_flush      = 4'hF;
         n_flush_left = m_flush_left - 1;
      end else if (exc || irq) begin
         e_flush      = 4'hF;
         e_pc_load    = 1'b1;
         e_new_pc     = 30'h40;
         n_epc        = mem_pc;
         n_code       = exc ? mem_exp_code : 3'd1;
         n_ie         = 1'b0;
         n_flush_left = 1;
      end else if (mem_en && mem_eret) begin
         e_flush      = 4'hF;
         e_pc_load    = 1'b1;
         e_new_pc     = m_epc;
         n_ie         = int_feature;
         n_flush_left = 1;
      end else if (br_taken) begin
         e_pc_load = 1'b1;
         e_new_pc  = br_addr;
         e_flush   = 4'b1000;
      end else if (ld_hazard) begin
         e_stall = 4'b1100;
         e_flush = 4'b0100;
      end
   endtask

   task automatic model_reset();
      m_flush_left = 0;
      m_epc        = '0;
      m_code       = 3'd0;
      m_ie         = 1'b0;
   endtask

   task automatic set_idle();
      reset = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0; br_taken = 0; br_addr = '0;
      mem_en = 0; mem_pc = '0; mem_exp_code = 3'd0; mem_eret = 0; int_req = 0;
   endtask

   // Inputs are already set; compare at the falling edge, then advance the model.
   task automatic apply();
      @(negedge clk);
      model_eval();
      check("stall",    {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, e_stall});
      check("flush",    {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, e_flush});
      check("pc_load",  {31'd0, pc_load}, {31'd0, e_pc_load});
      check("new_pc",   {2'd0, new_pc}, {2'd0, e_new_pc});
      check("epc",      {2'd0, epc}, {2'd0, m_epc});
      check("exp_code", {29'd0, exp_code}, {29'd0, m_code});
      check("int_en",   {31'd0, int_en}, {31'd0, m_ie});
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         m_flush_left = n_flush_left;
         m_epc        = n_epc;
         m_code       = n_code;
         m_ie         = n_ie;
      end
      #1;
   endtask

   initial begin
`ifdef PIPE_CTRL_INT_EN
      int_feature = 1'b1;
`else
      int_feature = 1'b0;
`endif
      set_idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 0;

      apply();
      apply();

      // Exception at 0x123, then its second flush cycle, then quiet.
      mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h123;
      apply();
      set_idle();
      check("exc_epc", {2'd0, epc}, 32'h123);
      check("exc_code", {29'd0, exp_code}, 32'd2);
      apply();
      apply();

      // Branch beats load-use.
      br_taken = 1; br_addr = 30'h200; ld_hazard = 1;
      apply();
      set_idle();

      // Pending exception held off by a data bus wait.
      mem_busy = 1; mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h77;
      apply();
      check("busy_epc", {2'd0, epc}, 32'h123);
      mem_busy = 0;
      apply();
      check("late_epc", {2'd0, epc}, 32'h77);
      set_idle();
      apply();

      // ERET returns to the latched epc.
      mem_en = 1; mem_eret = 1;
      apply();
      set_idle();
      check("eret_ie", {31'd0, int_en}, {31'd0, int_feature});
      apply();
      int_req = 1;
      apply();
      set_idle();
      apply();

      // Reset during the flush window abandons it.
      mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h55;
      apply();
      set_idle();
      reset = 1;
      apply();
      reset = 0;
      apply();
      check("rst_epc", {2'd0, epc}, 32'h0);

      for (int i = 0; i < 1500; i++) begin
         reset        = ($urandom_range(0, 59) == 0);
         if_busy      = ($urandom_range(0, 7) == 0);
         mem_busy     = ($urandom_range(0, 7) == 0);
         ld_hazard    = ($urandom_range(0, 2) == 0);
         br_taken     = ($urandom_range(0, 3) == 0);
         br_addr      = 30'($urandom);
         mem_en       = ($urandom_range(0, 1) == 0);
         mem_pc       = 30'($urandom);
         mem_exp_code = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         mem_eret     = ($urandom_range(0, 4) == 0);
         int_req      = ($urandom_range(0, 3) == 0);
         apply();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
